// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the multi-channel clock-enable generator.
// Config requests are widened to fixed maximum sizes so one validator serves every instance.
package clk_en_gen_pkg;

  localparam int CFG_CH_MAX_W   = 8;
  localparam int CFG_DATA_MAX_W = 32;

  typedef struct packed {
    logic [CFG_CH_MAX_W-1:0]   ch;
    logic [CFG_DATA_MAX_W-1:0] div;
    logic [CFG_DATA_MAX_W-1:0] phase;
  } cfg_req_t;

  function automatic int calc_ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Divisor 0 would make the wrap compare underflow; phase must fall inside the period.
  function automatic logic cfg_is_valid(input cfg_req_t req,
                                        input logic [CFG_DATA_MAX_W-1:0] num_ch);
    return (req.div != 32'd0) && (req.phase < req.div) &&
           (CFG_DATA_MAX_W'(req.ch) < num_ch);
  endfunction

endpackage

// File: rtl/clk_en_gen_ch.sv
// One enable channel: period counter, active/pending divisor and phase, strobe and square wave.
// Pending updates are only promoted at a stop, a sync, or a period boundary.
module clk_en_ch #(
  parameter int COUNTER_WIDTH = 16,
  parameter int DEFAULT_DIV   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     sync,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] cfg_div,
  input  logic [COUNTER_WIDTH-1:0] cfg_phase,
  output logic                     pend,
  output logic                     clk_en,
  output logic                     clk_sq
);

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [COUNTER_WIDTH-1:0] div_q, div_d;
  logic [COUNTER_WIDTH-1:0] phase_q, phase_d;
  logic [COUNTER_WIDTH-1:0] div_pend_q, div_pend_d;
  logic [COUNTER_WIDTH-1:0] phase_pend_q, phase_pend_d;
  logic                     pend_q, pend_d;
  logic                     en_q, en_d;
  logic                     sq_q, sq_d;
  logic                     wrap_s;
  logic                     apply_s;

  always_comb begin
    div_d        = div_q;
    phase_d      = phase_q;
    div_pend_d   = div_pend_q;
    phase_pend_d = phase_pend_q;
    pend_d       = pend_q;
    cnt_d        = cnt_q;
    en_d         = 1'b0;
    wrap_s       = (cnt_q == (div_q - COUNTER_WIDTH'(1)));
    apply_s      = pend_q & (~run | sync | wrap_s);

    if (apply_s) begin
      div_d   = div_pend_q;
      phase_d = phase_pend_q;
      pend_d  = 1'b0;
    end else begin
      pend_d  = pend_q;
    end

    // Stop and sync both restart the period at the (possibly new) phase without a strobe.
    if (!run || sync) begin
      cnt_d = phase_d;
    end else if (wrap_s) begin
      cnt_d = apply_s ? phase_d : '0;
      en_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + COUNTER_WIDTH'(1);
    end

    // The top only issues a load while no channel is pending, so it never collides with a promote.
    if (load) begin
      pend_d       = 1'b1;
      div_pend_d   = cfg_div;
      phase_pend_d = cfg_phase;
    end else begin
      pend_d       = pend_d;
    end

    sq_d = run & (cnt_d < (div_d >> 1));
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cnt_q        <= '0;
      div_q        <= COUNTER_WIDTH'(DEFAULT_DIV);
      phase_q      <= '0;
      div_pend_q   <= '0;
      phase_pend_q <= '0;
      pend_q       <= 1'b0;
      en_q         <= 1'b0;
      sq_q         <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      div_pend_q   <= div_pend_d;
      phase_pend_q <= phase_pend_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
      sq_q         <= sq_d;
    end
  end

  assign pend   = pend_q;
  assign clk_en = en_q;
  assign clk_sq = sq_q;

endmodule

// File: rtl/clk_en_gen_mc.sv
// Multi-channel clock-enable generator: config handshake, validation, error pulse and channel decode.
// The config port stays busy while any channel still holds an unapplied update.
module clk_en_gen_mc
  import clk_en_gen_pkg::*;
#(
  parameter int  NUM_CH        = 2,
  parameter int  COUNTER_WIDTH = 16,
  parameter int  DEFAULT_DIV   = 2,
  localparam int CH_W          = calc_ch_w(NUM_CH)
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [COUNTER_WIDTH-1:0] cfg_div,
  input  logic [COUNTER_WIDTH-1:0] cfg_phase,
  output logic                     cfg_err,
  input  logic [NUM_CH-1:0]        ch_run,
  input  logic                     sync,
  output logic [NUM_CH-1:0]        clk_en,
  output logic [NUM_CH-1:0]        clk_sq
);

  cfg_req_t          req_s;
  logic              cfg_xfer_s;
  logic              cfg_ok_s;
  logic              cfg_err_d, cfg_err_q;
  logic [NUM_CH-1:0] load_s;
  logic [NUM_CH-1:0] pend_s;

  assign cfg_ready = ~|pend_s;

  always_comb begin
    req_s.ch    = CFG_CH_MAX_W'(cfg_ch);
    req_s.div   = CFG_DATA_MAX_W'(cfg_div);
    req_s.phase = CFG_DATA_MAX_W'(cfg_phase);
    cfg_xfer_s  = cfg_valid & cfg_ready & rst;
    cfg_ok_s    = cfg_is_valid(req_s, CFG_DATA_MAX_W'(NUM_CH));
    cfg_err_d   = cfg_xfer_s & ~cfg_ok_s;
    load_s      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_xfer_s && cfg_ok_s && (32'(cfg_ch) == 32'(i))) begin
        load_s[i] = 1'b1;
      end else begin
        load_s[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_ch #(
      .COUNTER_WIDTH(COUNTER_WIDTH),
      .DEFAULT_DIV  (DEFAULT_DIV)
    ) u_ch (
      .clk_in   (clk_in),
      .rst      (rst),
      .run      (ch_run[g]),
      .sync     (sync),
      .load     (load_s[g]),
      .cfg_div  (cfg_div),
      .cfg_phase(cfg_phase),
      .pend     (pend_s[g]),
      .clk_en   (clk_en[g]),
      .clk_sq   (clk_sq[g])
    );
  end

endmodule

// File: tb/tb_clk_en_gen_mc.sv
// Self-checking bench for clk_en_gen_mc: directed scenarios plus randomized traffic
// compared against a behavioural channel model; a 3-channel instance covers channel range errors.
module tb_clk_en_gen_mc;

  localparam int NCH  = 2;
  localparam int DDIV = 2;

  logic        clk_in = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ch = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic [15:0] cfg_phase = 16'd0;
  logic [1:0]  ch_run = 2'b00;
  logic        sync = 1'b0;
  logic        cfg_ready, cfg_err;
  logic [1:0]  clk_en, clk_sq;

  logic        cfg_valid3 = 1'b0;
  logic [1:0]  cfg_ch3 = 2'd0;
  logic [15:0] cfg_div3 = 16'd0;
  logic [15:0] cfg_phase3 = 16'd0;
  logic [2:0]  ch_run3 = 3'b000;
  logic        cfg_ready3, cfg_err3;
  logic [2:0]  clk_en3, clk_sq3;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int m_cnt[NCH], m_div[NCH], m_ph[NCH], m_dp[NCH], m_pp[NCH];
  bit m_pend[NCH], m_en[NCH], m_sq[NCH];
  bit m_err;

  clk_en_gen_mc #(.NUM_CH(2), .COUNTER_WIDTH(16), .DEFAULT_DIV(DDIV)) u_dut (
    .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_err(cfg_err),
    .ch_run(ch_run), .sync(sync), .clk_en(clk_en), .clk_sq(clk_sq)
  );

  clk_en_gen_mc #(.NUM_CH(3), .COUNTER_WIDTH(16), .DEFAULT_DIV(DDIV)) u_dut3 (
    .clk_in(clk_in), .rst(rst), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .cfg_ch(cfg_ch3), .cfg_div(cfg_div3), .cfg_phase(cfg_phase3), .cfg_err(cfg_err3),
    .ch_run(ch_run3), .sync(sync), .clk_en(clk_en3), .clk_sq(clk_sq3)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [1:0] exp_en();
    return {m_en[1], m_en[0]};
  endfunction

  function automatic logic [1:0] exp_sq();
    return {m_sq[1], m_sq[0]};
  endfunction

  function automatic logic exp_ready();
    return !(m_pend[0] || m_pend[1]);
  endfunction

  task automatic promote(input int c);
    m_div[c]  = m_dp[c];
    m_ph[c]   = m_pp[c];
    m_pend[c] = 1'b0;
  endtask

  // Advance the reference model by one clk_in edge using the inputs currently driven.
  task automatic model_step();
    bit rdy, xfer, ok;
    rdy = exp_ready();
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        m_cnt[c] = 0; m_div[c] = DDIV; m_ph[c] = 0; m_pend[c] = 1'b0;
        m_en[c] = 1'b0; m_sq[c] = 1'b0;
      end
      m_err = 1'b0;
      return;
    end
    xfer  = cfg_valid && rdy;
    ok    = (cfg_div != 16'd0) && (cfg_phase < cfg_div);
    m_err = xfer && !ok;
    for (int c = 0; c < NCH; c++) begin
      if (!ch_run[c]) begin
        if (m_pend[c]) promote(c);
        m_cnt[c] = m_ph[c];
        m_en[c]  = 1'b0;
      end else if (sync) begin
        if (m_pend[c]) promote(c);
        m_cnt[c] = m_ph[c];
        m_en[c]  = 1'b0;
      end else if (m_cnt[c] == m_div[c] - 1) begin
        if (m_pend[c]) begin
          promote(c);
          m_cnt[c] = m_ph[c];
        end else begin
          m_cnt[c] = 0;
        end
        m_en[c] = 1'b1;
      end else begin
        m_cnt[c] = m_cnt[c] + 1;
        m_en[c]  = 1'b0;
      end
      m_sq[c] = ch_run[c] && (m_cnt[c] < m_div[c] / 2);
      if (xfer && ok && (int'(cfg_ch) == c)) begin
        m_pend[c] = 1'b1;
        m_dp[c]   = int'(cfg_div);
        m_pp[c]   = int'(cfg_phase);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; ch_run = 2'b11;
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd7; cfg_phase = 16'd1;
    repeat (3) tick();
    cfg_valid = 1'b0;
    checks++; if (clk_en !== 2'b00) begin failures++; $display("FAIL reset_en got=%b exp=00", clk_en); end
    checks++; if (clk_sq !== 2'b00) begin failures++; $display("FAIL reset_sq got=%b exp=00", clk_sq); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cfg_ready); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_default_div();
    logic [3:0] pat;
    pat = 4'b1010;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (clk_en !== {2{pat[i]}}) begin failures++; $display("FAIL default_en edge=%0d got=%b exp=%b", i + 1, clk_en, {2{pat[i]}}); end
      checks++; if (clk_sq !== {2{pat[i]}}) begin failures++; $display("FAIL default_sq edge=%0d got=%b exp=%b", i + 1, clk_sq, {2{pat[i]}}); end
    end
  endtask

  task automatic test_reconfig();
    int t0;
    int q[$];
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd4; cfg_phase = 16'd0;
    tick();
    cfg_valid = 1'b0;
    for (int i = 0; i < 10 && cfg_ready !== 1'b1; i++) tick();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reconf_ready_timeout got=%b exp=1", cfg_ready); end
    for (int i = 0; i < 10 && clk_en[0] !== 1'b1; i++) tick();
    checks++; if (clk_en[0] !== 1'b1) begin failures++; $display("FAIL reconf_strobe_timeout got=%b exp=1", clk_en[0]); end
    t0 = cyc;
    tick();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd5; cfg_phase = 16'd0;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reconf_busy got=%b exp=0", cfg_ready); end
    for (int i = 0; i < 16; i++) begin
      tick();
      if (clk_en[0] === 1'b1) q.push_back(cyc);
      checks++; if (clk_en !== exp_en() || cfg_ready !== exp_ready()) begin failures++; $display("FAIL reconf_model cyc=%0d got=%b/%b exp=%b/%b", cyc, clk_en, cfg_ready, exp_en(), exp_ready()); end
    end
    checks++;
    if (q.size() < 3 || q[0] - t0 != 4 || q[1] - q[0] != 5 || q[2] - q[1] != 5) begin
      failures++; $display("FAIL reconf_periods got=%0d strobes first_gap=%0d exp gaps 4,5,5", q.size(), (q.size() > 0) ? q[0] - t0 : -1);
    end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reconf_ready_after got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_sync();
    int s;
    int q0[$], q1[$];
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 12 && cfg_ready !== 1'b1; i++) tick();
      cfg_valid = 1'b1; cfg_ch = c[0]; cfg_div = 16'd4; cfg_phase = (c == 1) ? 16'd2 : 16'd0;
      tick();
      cfg_valid = 1'b0;
    end
    for (int i = 0; i < 12 && cfg_ready !== 1'b1; i++) tick();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL sync_ready_timeout got=%b exp=1", cfg_ready); end
    sync = 1'b1;
    tick();
    sync = 1'b0;
    s = cyc;
    checks++; if (clk_en !== 2'b00) begin failures++; $display("FAIL sync_edge_en got=%b exp=00", clk_en); end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clk_en[0] === 1'b1) q0.push_back(cyc);
      if (clk_en[1] === 1'b1) q1.push_back(cyc);
      checks++; if (clk_en !== exp_en() || clk_sq !== exp_sq()) begin failures++; $display("FAIL sync_model cyc=%0d got=%b/%b exp=%b/%b", cyc, clk_en, clk_sq, exp_en(), exp_sq()); end
    end
    checks++;
    if (q0.size() < 2 || q1.size() < 2 || q1[0] - s != 2 || q0[0] - q1[0] != 2 || q0[1] - q0[0] != 4 || q1[1] - q1[0] != 4) begin
      failures++; $display("FAIL sync_align got=%0d/%0d strobes exp ch1 at +2 ch0 at +4 period 4", q0.size(), q1.size());
    end
    for (int i = 0; i < 8 && m_cnt[0] != 3; i++) tick();
    sync = 1'b1;
    tick();
    sync = 1'b0;
    checks++; if (clk_en[0] !== 1'b0) begin failures++; $display("FAIL sync_wrap_coincide got=%b exp=0", clk_en[0]); end
  endtask

  task automatic test_cfg_reject();
    logic [15:0] dv[2];
    logic [15:0] ph[2];
    dv[0] = 16'd0; ph[0] = 16'd0;
    dv[1] = 16'd5; ph[1] = 16'd7;
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1; cfg_ch = k[0]; cfg_div = dv[k]; cfg_phase = ph[k];
      tick();
      cfg_valid = 1'b0;
      checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL reject_err case=%0d got=%b exp=1", k, cfg_err); end
      checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reject_ready case=%0d got=%b exp=1", k, cfg_ready); end
      tick();
      checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reject_err_pulse case=%0d got=%b exp=0", k, cfg_err); end
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (clk_en !== exp_en() || clk_sq !== exp_sq()) begin failures++; $display("FAIL reject_model cyc=%0d got=%b/%b exp=%b/%b", cyc, clk_en, clk_sq, exp_en(), exp_sq()); end
    end
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 16'd5; cfg_phase3 = 16'd0;
    tick();
    cfg_valid3 = 1'b0;
    checks++; if (cfg_err3 !== 1'b1 || cfg_ready3 !== 1'b1) begin failures++; $display("FAIL reject_ch_range got=%b/%b exp=1/1", cfg_err3, cfg_ready3); end
    cfg_valid3 = 1'b1; cfg_ch3 = 2'd2;
    tick();
    cfg_valid3 = 1'b0;
    checks++; if (cfg_err3 !== 1'b0 || cfg_ready3 !== 1'b0) begin failures++; $display("FAIL accept_ch2 got=%b/%b exp=0/0", cfg_err3, cfg_ready3); end
    tick();
    checks++; if (cfg_ready3 !== 1'b1) begin failures++; $display("FAIL stopped_apply3 got=%b exp=1", cfg_ready3); end
  endtask

  task automatic test_stopped_cfg();
    logic [7:0] pat;
    pat = 8'b1001_0010;
    ch_run[0] = 1'b0;
    tick();
    for (int i = 0; i < 12 && cfg_ready !== 1'b1; i++) tick();
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_div = 16'd3; cfg_phase = 16'd1;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL stop_busy got=%b exp=0", cfg_ready); end
    tick();
    checks++; if (cfg_ready !== 1'b1 || clk_en[0] !== 1'b0 || clk_sq[0] !== 1'b0) begin failures++; $display("FAIL stop_apply got=%b%b%b exp=100", cfg_ready, clk_en[0], clk_sq[0]); end
    ch_run[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (clk_en[0] !== pat[i] || clk_sq[0] !== pat[i]) begin failures++; $display("FAIL stop_restart edge=%0d got=%b/%b exp=%b", i + 1, clk_en[0], clk_sq[0], pat[i]); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_ch    = 1'($urandom_range(0, 1));
      cfg_div   = 16'($urandom_range(0, 9));
      cfg_phase = 16'($urandom_range(0, 9));
      ch_run    = {($urandom_range(0, 15) != 0), ($urandom_range(0, 15) != 0)};
      sync      = ($urandom_range(0, 31) == 0);
      tick();
      checks++;
      if (clk_en !== exp_en() || clk_sq !== exp_sq() || cfg_ready !== exp_ready() || cfg_err !== m_err) begin
        failures++;
        $display("FAIL rand cyc=%0d got en=%b sq=%b rdy=%b err=%b exp en=%b sq=%b rdy=%b err=%b",
                 cyc, clk_en, clk_sq, cfg_ready, cfg_err, exp_en(), exp_sq(), exp_ready(), m_err);
      end
    end
    cfg_valid = 1'b0; sync = 1'b0; ch_run = 2'b11;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 12 && cfg_ready !== 1'b1; i++) tick();
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_div = 16'd7; cfg_phase = 16'd3;
    tick();
    cfg_valid = 1'b0;
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", cfg_ready); end
    rst = 1'b0;
    tick();
    checks++; if (clk_en !== 2'b00 || clk_sq !== 2'b00 || cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state got=%b/%b/%b exp=00/00/1", clk_en, clk_sq, cfg_ready); end
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (clk_en !== ((i % 2 == 1) ? 2'b11 : 2'b00) || cfg_ready !== 1'b1) begin failures++; $display("FAIL rstmid_default edge=%0d got=%b/%b", i + 1, clk_en, cfg_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_reconfig();
    test_sync();
    test_cfg_reject();
    test_stopped_cfg();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
